// File: rtl/stopwatch_disp_pkg.sv
// Shared definitions for the stopwatch 6-digit display multiplexer.
//
// Contents:
//   NUM_DIGITS   number of scanned 7-segment digits
//   DP_MASK      digits whose decimal point is lit (bit k = digit k)
//   SEG_*        active-low segment codes, bit order {g,f,e,d,c,b,a}
//   DIGIT_DASH   buffer code meaning "value out of range, show a dash"
//   conv_state_t converter sequencing states (IDLE/CONV/DONE)
//   digit_to_seg buffer digit -> active-low segment code
package stopwatch_disp_pkg;

  localparam int NUM_DIGITS = 6;
  localparam logic [5:0] DP_MASK = 6'b010100;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Digits 0-9 are stored as plain BCD; one spare code marks a dash.
  localparam logic [3:0] DIGIT_DASH = 4'hA;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } conv_state_t;

  function automatic logic [6:0] digit_to_seg(input logic [3:0] d);
    logic [6:0] seg;
    case (d)
      4'd0:       seg = SEG_0;
      4'd1:       seg = SEG_1;
      4'd2:       seg = SEG_2;
      4'd3:       seg = SEG_3;
      4'd4:       seg = SEG_4;
      4'd5:       seg = SEG_5;
      4'd6:       seg = SEG_6;
      4'd7:       seg = SEG_7;
      4'd8:       seg = SEG_8;
      4'd9:       seg = SEG_9;
      DIGIT_DASH: seg = SEG_DASH;
      default:    seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/stopwatch_display_mux_bin2bcd.sv
// Sequential binary-to-BCD converter for one 7-bit value (0..127).
// Repeatedly subtracts 10 (one subtraction per cycle) counting tens;
// the remainder is the ones digit. Values above 99 are flagged instead
// of converted and finish immediately.
//
// Ports:
//   clk, rst_hw   clock and synchronous active-high reset
//   start         one-cycle pulse: capture value and begin
//   value[6:0]    binary input, sampled on start
//   done          one-cycle pulse: tens/ones/over_range are valid
//   tens, ones    BCD result
//   over_range    captured value was > 99
module bin2bcd_seq (
  input  logic       clk,
  input  logic       rst_hw,
  input  logic       start,
  input  logic [6:0] value,
  output logic       done,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       over_range
);

  logic [6:0] work;
  logic [3:0] tens_q;
  logic       busy;
  logic       done_q;
  logic       over_q;

  always_ff @(posedge clk) begin
    if (rst_hw) begin
      work   <= '0;
      tens_q <= '0;
      busy   <= 1'b0;
      done_q <= 1'b0;
      over_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        work   <= value;
        tens_q <= '0;
        over_q <= (value > 7'd99);
        busy   <= 1'b1;
      end else if (busy) begin
        // Out-of-range values skip the subtraction loop entirely.
        if (!over_q && (work >= 7'd10)) begin
          work   <= work - 7'd10;
          tens_q <= tens_q + 4'd1;
        end else begin
          busy   <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  // When done is asserted the remainder is below 10, so the low nibble
  // holds the complete ones digit.
  assign done       = done_q;
  assign tens       = tens_q;
  assign ones       = work[3:0];
  assign over_range = over_q;

endmodule

// File: rtl/stopwatch_display_mux.sv
// Time-multiplexed 6-digit common-anode 7-segment driver for the stopwatch.
// Once per refresh frame the q0/q1/q2 inputs are snapshotted, converted to
// BCD by a single time-shared sequential converter, and the six display
// digits are updated atomically. One digit is lit at a time; all outputs
// are registered and active-low.
//
// Parameters:
//   REFRESH_MAX   clk cycles each digit stays lit (>= 64)
//   BLINK_FRAMES  frames per blink half-period (blink build only)
//
// Ports:
//   clk, rst_hw      50 MHz clock, synchronous active-high reset
//   q0, q1, q2       centiseconds, seconds, minutes (binary)
//   overflow         stopwatch reached maximum count
//   seg_n[6:0]       segments {g,f,e,d,c,b,a}, active-low
//   dp_n             decimal point, active-low (digits 2 and 4)
//   an_n[5:0]        digit anodes, active-low, bit k = digit k
//
// Build option: define STOPWATCH_DISP_OVERFLOW_BLINK_EN to blank the
// display every other BLINK_FRAMES frames while overflow is high.
module stopwatch_display_mux
  import stopwatch_disp_pkg::*;
#(
  parameter int REFRESH_MAX  = 50000,
  parameter int BLINK_FRAMES = 40
) (
  input  logic       clk,
  input  logic       rst_hw,
  input  logic [6:0] q0,
  input  logic [6:0] q1,
  input  logic [6:0] q2,
  input  logic       overflow,
  output logic [6:0] seg_n,
  output logic       dp_n,
  output logic [5:0] an_n
);

  localparam int TICK_W = $clog2(REFRESH_MAX);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(REFRESH_MAX - 1);

  logic [TICK_W-1:0] tick;
  logic [2:0]        digit_idx;
  logic              boot;
  logic              tick_last;
  logic              frame_wrap;
  logic              frame_start;

  conv_state_t state;
  conv_state_t state_next;
  logic [1:0]  sel;
  logic        launch;

  logic [6:0] snap [3];
  logic [3:0] stage [NUM_DIGITS];
  logic [3:0] buffer [NUM_DIGITS];

  logic [6:0] conv_value;
  logic       bcd_done;
  logic       bcd_over;
  logic [3:0] bcd_tens;
  logic [3:0] bcd_ones;
  logic [3:0] res_tens;
  logic [3:0] res_ones;
  logic       blank;

  assign tick_last  = (tick == TICK_LAST);
  assign frame_wrap = tick_last && (digit_idx == 3'd5);
  // boot makes the very first cycle out of reset a frame start so the
  // display does not wait a whole frame for its first real values.
  assign frame_start = frame_wrap || boot;

  // Converter sequencing state register.
  always_ff @(posedge clk) begin
    if (rst_hw) state <= IDLE;
    else        state <= state_next;
  end

  // Frame starts arriving while busy are dropped; with REFRESH_MAX >= 64
  // the conversion always finishes long before the next one.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (frame_start) state_next = CONV;
      CONV:    if (bcd_done && (sel == 2'd2)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    conv_value = snap[0];
    case (sel)
      2'd1:    conv_value = snap[1];
      2'd2:    conv_value = snap[2];
      default: conv_value = snap[0];
    endcase
  end

  bin2bcd_seq u_bin2bcd (
    .clk        (clk),
    .rst_hw     (rst_hw),
    .start      (launch),
    .value      (conv_value),
    .done       (bcd_done),
    .tens       (bcd_tens),
    .ones       (bcd_ones),
    .over_range (bcd_over)
  );

  assign res_tens = bcd_over ? DIGIT_DASH : bcd_tens;
  assign res_ones = bcd_over ? DIGIT_DASH : bcd_ones;

  // Scan timing, snapshot capture, per-value result staging and the
  // single-cycle commit of all six digits into the display buffer.
  // Results land in stage first so the visible buffer never mixes digits
  // from two different snapshots.
  always_ff @(posedge clk) begin
    if (rst_hw) begin
      tick      <= '0;
      digit_idx <= '0;
      boot      <= 1'b1;
      sel       <= '0;
      launch    <= 1'b0;
      for (int i = 0; i < 3; i++) snap[i] <= '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        stage[i]  <= '0;
        buffer[i] <= '0;
      end
    end else begin
      boot   <= 1'b0;
      launch <= 1'b0;

      if (tick_last) begin
        tick      <= '0;
        digit_idx <= (digit_idx == 3'd5) ? 3'd0 : digit_idx + 3'd1;
      end else begin
        tick <= tick + 1'b1;
      end

      if ((state == IDLE) && frame_start) begin
        snap[0] <= q0;
        snap[1] <= q1;
        snap[2] <= q2;
        sel     <= 2'd0;
        launch  <= 1'b1;
      end

      if ((state == CONV) && bcd_done) begin
        case (sel)
          2'd0: begin stage[0] <= res_ones; stage[1] <= res_tens; end
          2'd1: begin stage[2] <= res_ones; stage[3] <= res_tens; end
          default: begin stage[4] <= res_ones; stage[5] <= res_tens; end
        endcase
        if (sel != 2'd2) begin
          sel    <= sel + 2'd1;
          launch <= 1'b1;
        end
      end

      if (state == DONE) begin
        for (int i = 0; i < NUM_DIGITS; i++) buffer[i] <= stage[i];
      end
    end
  end

`ifdef STOPWATCH_DISP_OVERFLOW_BLINK_EN
  localparam int FRAME_W = $clog2(BLINK_FRAMES) + 1;

  logic [FRAME_W-1:0] frame_cnt;
  logic               blink_phase;

  // Blink phase flips every BLINK_FRAMES frames while overflow is held;
  // dropping overflow restarts the pattern from the lit phase.
  always_ff @(posedge clk) begin
    if (rst_hw || !overflow) begin
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (frame_wrap) begin
      if (frame_cnt == FRAME_W'(BLINK_FRAMES - 1)) begin
        frame_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  assign blank = blink_phase;
`else
  logic unused_blink_cfg;
  assign unused_blink_cfg = overflow ^ (BLINK_FRAMES == 0);
  assign blank = 1'b0;
`endif

  // Registered pin drivers: one cycle behind digit_idx. Blanking only
  // turns the anodes and decimal point off; scanning carries on.
  always_ff @(posedge clk) begin
    if (rst_hw) begin
      an_n  <= 6'h3F;
      seg_n <= SEG_BLANK;
      dp_n  <= 1'b1;
    end else begin
      seg_n <= digit_to_seg(buffer[digit_idx]);
      if (blank) begin
        an_n <= 6'h3F;
        dp_n <= 1'b1;
      end else begin
        an_n <= ~(6'd1 << digit_idx);
        dp_n <= ~DP_MASK[digit_idx];
      end
    end
  end

endmodule

// File: tb/tb_stopwatch_display_mux.sv
// Self-checking bench for stopwatch_display_mux (REFRESH_MAX=64,
// BLINK_FRAMES=2). Expected digit patterns are queued when inputs are
// driven and popped as the scan reaches each digit.
module tb_stopwatch_display_mux;
  import stopwatch_disp_pkg::*;

  localparam int RM = 64;
`ifdef STOPWATCH_DISP_OVERFLOW_BLINK_EN
  localparam bit BLINK_ON = 1'b1;
`else
  localparam bit BLINK_ON = 1'b0;
`endif

  typedef struct packed {
    logic [5:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_entry_t;

  logic       clk = 1'b0;
  logic       rst_hw = 1'b1;
  logic [6:0] q0 = '0;
  logic [6:0] q1 = '0;
  logic [6:0] q2 = '0;
  logic       overflow = 1'b0;
  logic [6:0] seg_n;
  logic       dp_n;
  logic [5:0] an_n;

  int checks = 0;
  int failures = 0;
  exp_entry_t exp_q[$];

  stopwatch_display_mux #(.REFRESH_MAX(RM), .BLINK_FRAMES(2)) dut (
    .clk      (clk),
    .rst_hw   (rst_hw),
    .q0       (q0),
    .q1       (q1),
    .q2       (q2),
    .overflow (overflow),
    .seg_n    (seg_n),
    .dp_n     (dp_n),
    .an_n     (an_n)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [6:0] model_seg(input int v, input bit tens);
    int d;
    if (v > 99) return 7'h3F;
    d = tens ? v / 10 : v % 10;
    case (d)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  task automatic push_expected(input int a, input int b, input int c);
    exp_entry_t e;
    int v;
    for (int k = 0; k < 6; k++) begin
      v = (k < 2) ? a : ((k < 4) ? b : c);
      e.an = 6'h3F;
      e.an[k] = 1'b0;
      e.seg = model_seg(v, (k % 2) == 1);
      e.dp = !((k == 2) || (k == 4));
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_digit0(output bit ok);
    logic [5:0] prev;
    prev = an_n;
    ok = 1'b0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clk);
      if (an_n == 6'b111110 && prev != 6'b111110) ok = 1'b1;
      prev = an_n;
    end
  endtask

  task automatic test_reset;
    rst_hw = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (an_n !== 6'h3F) begin failures++; $display("[TB] FAIL reset_an: got %b expected %b", an_n, 6'h3F); end
    checks++;
    if (seg_n !== 7'h7F) begin failures++; $display("[TB] FAIL reset_seg: got %h expected %h", seg_n, 7'h7F); end
    checks++;
    if (dp_n !== 1'b1) begin failures++; $display("[TB] FAIL reset_dp: got %b expected 1", dp_n); end
    rst_hw = 1'b0;
    @(negedge clk);
    checks++;
    if (an_n !== 6'b111110 || seg_n !== 7'h40 || dp_n !== 1'b1)
      begin failures++; $display("[TB] FAIL first_digit: got an=%b seg=%h dp=%b expected an=111110 seg=40 dp=1", an_n, seg_n, dp_n); end
  endtask

  task automatic test_static;
    bit ok;
    exp_entry_t e;
    q0 = 7'd42; q1 = 7'd7; q2 = 7'd59;
    push_expected(42, 7, 59);
    wait_digit0(ok);
    if (ok) wait_digit0(ok);
    if (!ok) begin checks++; failures++; $display("[TB] FAIL static_sync: got timeout expected digit 0"); end
    for (int k = 0; k < 6; k++) begin
      repeat (k == 0 ? 32 : 64) @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (an_n !== e.an || seg_n !== e.seg || dp_n !== e.dp)
        begin failures++; $display("[TB] FAIL static_d%0d: got an=%b seg=%h dp=%b expected an=%b seg=%h dp=%b", k, an_n, seg_n, dp_n, e.an, e.seg, e.dp); end
    end
  endtask

  task automatic test_mid_frame;
    bit ok;
    exp_entry_t e;
    ok = 1'b0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clk);
      if (an_n == 6'b110111) ok = 1'b1;
    end
    if (!ok) begin checks++; failures++; $display("[TB] FAIL mid_sync: got timeout expected digit 3"); end
    q0 = 7'd13;
    wait_digit0(ok);
    checks++;
    if (!ok || seg_n !== 7'h24)
      begin failures++; $display("[TB] FAIL mid_old: got seg=%h ok=%0d expected seg=24 ok=1", seg_n, ok); end
    push_expected(13, 7, 59);
    for (int k = 0; k < 6; k++) begin
      repeat (k == 0 ? 32 : 64) @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (an_n !== e.an || seg_n !== e.seg)
        begin failures++; $display("[TB] FAIL mid_new_d%0d: got an=%b seg=%h expected an=%b seg=%h", k, an_n, seg_n, e.an, e.seg); end
    end
  endtask

  task automatic test_out_of_range;
    bit ok;
    exp_entry_t e;
    q0 = 7'd100;
    push_expected(100, 7, 59);
    wait_digit0(ok);
    if (ok) wait_digit0(ok);
    if (!ok) begin checks++; failures++; $display("[TB] FAIL oor_sync: got timeout expected digit 0"); end
    for (int k = 0; k < 6; k++) begin
      repeat (k == 0 ? 32 : 64) @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (an_n !== e.an || seg_n !== e.seg)
        begin failures++; $display("[TB] FAIL oor_d%0d: got an=%b seg=%h expected an=%b seg=%h", k, an_n, seg_n, e.an, e.seg); end
    end
  endtask

  task automatic test_reset_mid_conv;
    bit ok;
    exp_entry_t e;
    q0 = 7'd99; q1 = 7'd59; q2 = 7'd59;
    wait_digit0(ok);
    checks++;
    if (!ok || dut.state !== CONV)
      begin failures++; $display("[TB] FAIL rmc_in_conv: got state=%0d ok=%0d expected state=%0d ok=1", dut.state, ok, CONV); end
    rst_hw = 1'b1;
    q0 = 7'd5; q1 = 7'd30; q2 = 7'd12;
    @(negedge clk);
    checks++;
    if (dut.state !== IDLE)
      begin failures++; $display("[TB] FAIL rmc_idle: got state=%0d expected %0d", dut.state, IDLE); end
    checks++;
    if (an_n !== 6'h3F || seg_n !== 7'h7F || dp_n !== 1'b1)
      begin failures++; $display("[TB] FAIL rmc_outputs: got an=%b seg=%h dp=%b expected an=111111 seg=7f dp=1", an_n, seg_n, dp_n); end
    repeat (2) @(negedge clk);
    rst_hw = 1'b0;
    @(negedge clk);
    checks++;
    if (an_n !== 6'b111110 || seg_n !== 7'h40)
      begin failures++; $display("[TB] FAIL rmc_cleared: got an=%b seg=%h expected an=111110 seg=40", an_n, seg_n); end
    push_expected(5, 30, 12);
    wait_digit0(ok);
    if (ok) wait_digit0(ok);
    if (!ok) begin checks++; failures++; $display("[TB] FAIL rmc_sync: got timeout expected digit 0"); end
    for (int k = 0; k < 6; k++) begin
      repeat (k == 0 ? 32 : 64) @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (an_n !== e.an || seg_n !== e.seg || dp_n !== e.dp)
        begin failures++; $display("[TB] FAIL rmc_d%0d: got an=%b seg=%h dp=%b expected an=%b seg=%h dp=%b", k, an_n, seg_n, dp_n, e.an, e.seg, e.dp); end
    end
  endtask

  task automatic test_overflow;
    bit ok;
    bit dark;
    exp_entry_t e;
    int d;
    wait_digit0(ok);
    if (!ok) begin checks++; failures++; $display("[TB] FAIL ovf_sync: got timeout expected digit 0"); end
    overflow = 1'b1;
    // Frames counted from here: 2 lit, 2 dark, 2 lit, 2 dark when blinking.
    for (int i = 0; i < 8; i++) begin
      dark = BLINK_ON && (((i / 2) % 2) == 1);
      e.an = dark ? 6'h3F : 6'b111011;
      e.seg = 7'h00;
      e.dp = dark ? 1'b1 : 1'b0;
      exp_q.push_back(e);
      repeat (i == 0 ? 160 : 6 * RM) @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (an_n !== e.an || dp_n !== e.dp)
        begin failures++; $display("[TB] FAIL ovf_frame%0d: got an=%b dp=%b expected an=%b dp=%b", i, an_n, dp_n, e.an, e.dp); end
    end
    overflow = 1'b0;
    for (int j = 1; j <= 6; j++) begin
      d = (2 + j) % 6;
      e.an = 6'h3F;
      e.an[d] = 1'b0;
      e.seg = 7'h00;
      e.dp = 1'b1;
      exp_q.push_back(e);
      repeat (RM) @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (an_n !== e.an)
        begin failures++; $display("[TB] FAIL ovf_off_d%0d: got an=%b expected an=%b", d, an_n, e.an); end
    end
  endtask

  initial begin
    test_reset();
    test_static();
    test_mid_frame();
    test_out_of_range();
    test_reset_mid_conv();
    test_overflow();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
